control_unit: RTL and testbench

Instruction decoder for the 8-bit CPU. Takes the 4-bit opcode of the current instruction and produces the ALU operation select and the memory, register-file and jump control strobes. It sits between instruction fetch and the datapath (ALU, register file, data memory, PC logic). Outputs are registered: each decode lands one clock after the opcode is sampled.

---
 rtl/cpu_pkg.sv | 41 ++++
 rtl/control_decode.sv | 42 ++++
 rtl/control_unit.sv | 40 ++++
 tb/tb_control_unit.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit CPU: opcodes, ALU operation selects and the
// bundled control word produced by the instruction decoder.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'b0000,
        OP_ADD   = 4'b0001,
        OP_SUB   = 4'b0010,
        OP_LOAD  = 4'b0110,
        OP_STORE = 4'b0111,
        OP_JUMP  = 4'b1111
    } opcode_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_LOAD  = 2'b10,
        ALU_STORE = 2'b11
    } alu_op_e;

    typedef struct packed {
        alu_op_e alu_op;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    jump;
        logic    illegal_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        alu_op: ALU_ADD, reg_write: 1'b0, mem_read: 1'b0,
        mem_write: 1'b0, jump: 1'b0, illegal_op: 1'b0
    };

    // Reserved opcodes behave as NOP but are flagged.
    localparam ctrl_t CTRL_ILLEGAL = '{
        alu_op: ALU_ADD, reg_write: 1'b0, mem_read: 1'b0,
        mem_write: 1'b0, jump: 1'b0, illegal_op: 1'b1
    };

endpackage

// File: rtl/control_decode.sv
// Combinational opcode-to-control-word decode; any unlisted opcode is reserved.
module control_decode
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = CTRL_ILLEGAL;
        case (opcode)
            OP_NOP: ctrl = CTRL_NOP;
            OP_ADD: begin
                ctrl           = CTRL_NOP;
                ctrl.alu_op    = ALU_ADD;
                ctrl.reg_write = 1'b1;
            end
            OP_SUB: begin
                ctrl           = CTRL_NOP;
                ctrl.alu_op    = ALU_SUB;
                ctrl.reg_write = 1'b1;
            end
            OP_LOAD: begin
                ctrl           = CTRL_NOP;
                ctrl.alu_op    = ALU_LOAD;
                ctrl.reg_write = 1'b1;
                ctrl.mem_read  = 1'b1;
            end
            OP_STORE: begin
                ctrl           = CTRL_NOP;
                ctrl.alu_op    = ALU_STORE;
                ctrl.mem_write = 1'b1;
            end
            OP_JUMP: begin
                ctrl      = CTRL_NOP;
                ctrl.jump = 1'b1;
            end
            default: ctrl = CTRL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Instruction decoder with a single registered output stage: one-clock latency,
// one decode per cycle, synchronous reset to the NOP control word.
module control_unit
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    output logic [1:0] alu_op,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       jump,
    output logic       illegal_op
);

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    control_decode u_decode (
        .opcode (opcode),
        .ctrl   (ctrl_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= CTRL_NOP;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign alu_op     = ctrl_q.alu_op;
    assign mem_read   = ctrl_q.mem_read;
    assign mem_write  = ctrl_q.mem_write;
    assign reg_write  = ctrl_q.reg_write;
    assign jump       = ctrl_q.jump;
    assign illegal_op = ctrl_q.illegal_op;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: hand-written decode table, latency, reset
// priority/recovery and per-cycle invariants.
module tb_control_unit;

    logic       clk;
    logic       rst;
    logic [3:0] opcode;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       jump;
    logic       illegal_op;

    int unsigned total;
    int unsigned bad;

    control_unit dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .alu_op     (alu_op),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .jump       (jump),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed as {alu_op[1:0], reg_write, mem_read, mem_write, jump, illegal_op}.
    function automatic logic [6:0] table_exp(input logic [3:0] op);
        case (op)
            4'b0000: table_exp = 7'b00_00000;
            4'b0001: table_exp = 7'b00_10000;
            4'b0010: table_exp = 7'b01_10000;
            4'b0110: table_exp = 7'b10_11000;
            4'b0111: table_exp = 7'b11_00100;
            4'b1111: table_exp = 7'b00_00010;
            default: table_exp = 7'b00_00001;
        endcase
    endfunction

    function automatic logic [6:0] observed();
        observed = {alu_op, reg_write, mem_read, mem_write, jump, illegal_op};
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_invariants(input string tag);
        logic [6:0] v;
        v = 7'(mem_read & mem_write);
        check({tag, "/inv_rd_wr"}, v, 7'd0);
        v = 7'(jump & (reg_write | mem_read | mem_write));
        check({tag, "/inv_jump_excl"}, v, 7'd0);
        v = 7'(jump & illegal_op);
        check({tag, "/inv_jump_ill"}, v, 7'd0);
    endtask

    // Drive on the falling edge, observe 1 time unit after the next rising edge.
    task automatic step(input logic r, input logic [3:0] op);
        @(negedge clk);
        rst    = r;
        opcode = op;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        opcode = 4'b0001;

        // Reset has priority over a valid ADD opcode for two edges.
        step(1'b1, 4'b0001);
        check("reset_1", observed(), 7'b00_00000);
        step(1'b1, 4'b0001);
        check("reset_2", observed(), 7'b00_00000);
        check_invariants("reset");

        step(1'b0, 4'b0001);
        check("post_reset_add", observed(), 7'b00_10000);

        step(1'b0, 4'b0010);
        check("sub_after_add", observed(), 7'b01_10000);

        step(1'b0, 4'b0110);
        check("load", observed(), 7'b10_11000);

        step(1'b0, 4'b0111);
        check("store", observed(), 7'b11_00100);

        step(1'b0, 4'b1111);
        check("jump", observed(), 7'b00_00010);
        check_invariants("jump");

        // Latency: an opcode change before the edge must not show until the edge.
        @(negedge clk);
        opcode = 4'b0110;
        #1;
        check("hold_before_edge", observed(), 7'b00_00010);
        @(posedge clk);
        #1;
        check("load_after_edge", observed(), 7'b10_11000);

        // Mid-stream reset, then clean resume on a reserved opcode.
        step(1'b1, 4'b1111);
        check("midstream_reset", observed(), 7'b00_00000);
        step(1'b0, 4'b1010);
        check("resume_reserved", observed(), 7'b00_00001);

        // Back-to-back sweep of all 16 opcodes.
        for (int i = 0; i < 16; i++) begin
            logic [3:0] op;
            op = 4'(i);
            step(1'b0, op);
            check($sformatf("sweep_op%0h", op), observed(), table_exp(op));
            check_invariants($sformatf("sweep_op%0h", op));
        end

        // Descending sweep so each opcode follows a different predecessor.
        for (int i = 15; i >= 0; i--) begin
            logic [3:0] op;
            op = 4'(i);
            step(1'b0, op);
            check($sformatf("rsweep_op%0h", op), observed(), table_exp(op));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
